mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter driving a 4:1 one-bit mux select.
// Optional forced release after HOLD_MAX cycles when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       q,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] sel;
  logic       nat_rel;
  logic       force_rel;
  logic [3:0] cand;
  logic [2:0] pick;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("mux4_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  // Returns {found, index} of the first set bit of mask, scanning ptr+1 .. ptr+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!res[2] && mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;
  logic       timeout_r;
`endif

  always_comb begin
    nat_rel   = done || !req[sel];
    force_rel = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
    force_rel = (state == GRANT) && !nat_rel && (hold_cnt == HOLD_LAST);
`endif
    // A timed-out owner is excluded from the very decision that releases it.
    cand = req;
    if (force_rel) cand[sel] = 1'b0;
    pick = rr_pick(cand, last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      last  <= 2'd3;
      busy  <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_r <= 1'b0;
`endif
    end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
      timeout_r <= force_rel;
`endif
      if (state == IDLE || nat_rel || force_rel) begin
        if (pick[2]) begin
          state <= GRANT;
          gnt   <= 4'b0001 << pick[1:0];
          sel   <= pick[1:0];
          last  <= pick[1:0];
          busy  <= 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
          hold_cnt <= 8'd0;
`endif
        end else begin
          // Select lines deliberately keep their last value while idle.
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
          hold_cnt <= 8'd0;
`endif
        end
      end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
        hold_cnt <= hold_cnt + 8'd1;
`endif
      end
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign s1 = sel[1];
  assign s0 = sel[0];
  assign q  = busy ? d[sel] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: per-cycle reference model plus directed literal checks.
module tb_mux4_rr_arbiter;

  localparam int HOLD_MAX = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TO_BUILD = 1'b1;
`else
  localparam bit TO_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] d;
  logic [3:0] gnt;
  logic       s1, s0, busy, q, timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .d(d),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .q(q), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when idle; grant_cycles counts GRANT cycles of the owner.
  int m_owner = -1;
  int m_sel   = 0;
  int m_last  = 3;
  int m_cyc   = 0;
  bit m_to    = 1'b0;
  bit m_init  = 1'b0;

  always @(posedge clk) begin
    int nxt;
    bit forced;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_last = 3; m_cyc = 0; m_to = 1'b0; m_init = 1'b1;
    end else begin
      m_to = 1'b0;
      nxt  = -1;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++)
          if (nxt < 0 && req[(m_last + k) % 4]) nxt = (m_last + k) % 4;
        if (nxt >= 0) begin
          m_owner = nxt; m_sel = nxt; m_last = nxt; m_cyc = 1;
        end
      end else begin
        forced = TO_BUILD && !done && req[m_owner] && (m_cyc >= HOLD_MAX);
        if (done || !req[m_owner] || forced) begin
          for (int k = 1; k <= 3; k++)
            if (nxt < 0 && req[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
          if (nxt < 0 && req[m_owner] && !forced) nxt = m_owner;
          m_to = forced;
          if (nxt >= 0) begin
            m_owner = nxt; m_sel = nxt; m_last = nxt; m_cyc = 1;
          end else begin
            m_owner = -1;
          end
        end else begin
          m_cyc++;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    #1;
    if (m_init) begin
      e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e_sel = 2'(m_sel);
      check("model_gnt",  {4'b0, gnt}, {4'b0, e_gnt});
      check("model_sel",  {6'b0, s1, s0}, {6'b0, e_sel});
      check("model_busy", {7'b0, busy}, {7'b0, (m_owner >= 0)});
      check("model_q",    {7'b0, q}, {7'b0, (m_owner >= 0) ? d[e_sel] : 1'b0});
      check("model_to",   {7'b0, timeout}, {7'b0, m_to});
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] pats [4];
    logic [3:0] oh;
    logic [3:0] exp_order [4];
    rst = 1'b1; req = 4'b0000; done = 1'b0; d = 4'b0000;
    tick; tick;
    check("rst_gnt",  {4'b0, gnt}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_sel",  {6'b0, s1, s0}, 8'h00);
    check("rst_q",    {7'b0, q}, 8'h00);
    check("rst_to",   {7'b0, timeout}, 8'h00);

    // Single requester, then release to idle
    rst = 1'b0; req = 4'b0001; d = 4'b0001;
    tick;
    check("single_gnt",  {4'b0, gnt}, 8'h01);
    check("single_busy", {7'b0, busy}, 8'h01);
    check("single_q",    {7'b0, q}, 8'h01);
    done = 1'b1; req = 4'b0000;
    tick;
    check("release_gnt", {4'b0, gnt}, 8'h00);
    check("release_q",   {7'b0, q}, 8'h00);
    // done while idle must not start anything
    tick;
    check("idle_done_busy", {7'b0, busy}, 8'h00);
    done = 1'b0;

    // Full contention, done every third cycle
    rst = 1'b1; tick; rst = 1'b0;
    req = 4'b1111; d = 4'b1010;
    tick;
    check("rr_first", {4'b0, gnt}, 8'h01);
    exp_order[0] = 4'b0010; exp_order[1] = 4'b0100;
    exp_order[2] = 4'b1000; exp_order[3] = 4'b0001;
    for (int g = 0; g < 4; g++) begin
      tick;
      tick;
      check("rr_hold_busy", {7'b0, busy}, 8'h01);
      done = 1'b1;
      tick;
      done = 1'b0;
      check("rr_next", {4'b0, gnt}, {4'b0, exp_order[g]});
    end

    // Owner 2 drops its request; next search begins after 2
    req = 4'b0100; done = 1'b1;
    tick;
    done = 1'b0;
    check("own2_gnt", {4'b0, gnt}, 8'h04);
    req = 4'b0000;
    tick;
    check("drop_gnt", {4'b0, gnt}, 8'h00);
    req = 4'b1001;
    tick;
    check("after2_gnt", {4'b0, gnt}, 8'h08);
    check("after2_sel", {6'b0, s1, s0}, 8'h03);

    // Mux select: q follows only the owner's data bit
    for (int i = 0; i < 4; i++) begin
      req = 4'b0001 << i;
      tick;
      oh = 4'b0001 << i;
      pats[0] = 4'b0000; pats[1] = oh; pats[2] = ~oh; pats[3] = 4'b1111;
      check("sel_owner", {4'b0, gnt}, {4'b0, oh});
      for (int p = 0; p < 4; p++) begin
        d = pats[p];
        #1;
        check("sel_q", {7'b0, q}, {7'b0, (p == 1 || p == 3)});
      end
    end

    // Reset in the middle of a grant to source 2
    req = 4'b0100; d = 4'b1111;
    tick;
    check("pre_rst_gnt", {4'b0, gnt}, 8'h04);
    rst = 1'b1;
    tick;
    check("midrst_gnt",  {4'b0, gnt}, 8'h00);
    check("midrst_sel",  {6'b0, s1, s0}, 8'h00);
    check("midrst_q",    {7'b0, q}, 8'h00);
    rst = 1'b0; req = 4'b1111;
    tick;
    check("post_rst_gnt", {4'b0, gnt}, 8'h01);

    // Long hold with two requesters and no done
    rst = 1'b1; tick; rst = 1'b0;
    req = 4'b0011; done = 1'b0;
    tick;
    check("hold_first", {4'b0, gnt}, 8'h01);
    tick; tick; tick;
    check("hold_e3", {4'b0, gnt}, 8'h01);
    tick;
`ifdef MUX4_ARB_TIMEOUT_EN
    check("to_gnt",   {4'b0, gnt}, 8'h02);
    check("to_pulse", {7'b0, timeout}, 8'h01);
    tick;
    check("to_clear", {7'b0, timeout}, 8'h00);
`else
    check("nto_gnt", {4'b0, gnt}, 8'h01);
    check("nto_to",  {7'b0, timeout}, 8'h00);
    tick; tick;
    check("nto_gnt_late", {4'b0, gnt}, 8'h01);
`endif
    req = 4'b0000;
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $fatal(1);
  end

endmodule
